// File: rtl/game_pkg.sv
// Shared game constants: screen and sprite geometry, FSM state encoding and
// the clamped-descent helper used by the missile controllers.
package game_pkg;

  localparam int unsigned SCREEN_H          = 768;
  localparam int unsigned PLAYER_W          = 48;
  localparam int unsigned PLAYER_H          = 64;
  localparam int unsigned MISSLE_W          = 8;
  localparam int unsigned MISSLE_H          = 16;
  localparam int unsigned COUNTER_LIMIT_DEF = 90000;
  localparam int unsigned STEP_DEF          = 2;

  // Refresh counter width; COUNTER_LIMIT must stay below 2**CNT_W.
  localparam int unsigned CNT_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_FLY    = 2'd2,
    ST_HIT    = 2'd3
  } state_e;

  // Move a y coordinate down by step, clamping at limit. The sum is 13 bits
  // wide so positions near 4095 cannot wrap back to the top of the screen.
  function automatic logic [11:0] step_clamp(input logic [11:0] y,
                                             input logic [11:0] step,
                                             input logic [11:0] limit);
    logic [12:0] sum;
    sum = {1'b0, y} + {1'b0, step};
    if (sum > {1'b0, limit}) step_clamp = limit;
    else                     step_clamp = sum[11:0];
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Purely combinational axis-aligned rectangle intersection test.
// Rectangles are half-open [x, x+w) x [y, y+h), so rectangles that only
// touch along an edge do not overlap.
module rect_overlap (
  input  logic [11:0] a_x_i,
  input  logic [11:0] a_y_i,
  input  logic [11:0] a_w_i,
  input  logic [11:0] a_h_i,
  input  logic [11:0] b_x_i,
  input  logic [11:0] b_y_i,
  input  logic [11:0] b_w_i,
  input  logic [11:0] b_h_i,
  output logic        overlap_o
);

  logic [12:0] a_right, a_bottom, b_right, b_bottom;

  // Far edges in 13 bits so a sprite near the right/bottom limit cannot wrap.
  assign a_right  = {1'b0, a_x_i} + {1'b0, a_w_i};
  assign a_bottom = {1'b0, a_y_i} + {1'b0, a_h_i};
  assign b_right  = {1'b0, b_x_i} + {1'b0, b_w_i};
  assign b_bottom = {1'b0, b_y_i} + {1'b0, b_h_i};

  assign overlap_o = (a_right  > {1'b0, b_x_i}) && (b_right  > {1'b0, a_x_i}) &&
                     (a_bottom > {1'b0, b_y_i}) && (b_bottom > {1'b0, a_y_i});

endmodule

// File: rtl/enemy_missle_ctl.sv
// Enemy missile controller: latches a launch position on an accepted fire
// request, steps the missile down once per refresh interval and retires it
// at the bottom of the screen or on contact with the player (hit pulse).
module enemy_missle_ctl
  import game_pkg::*;
#(
  parameter int unsigned COUNTER_LIMIT = COUNTER_LIMIT_DEF,
  parameter int unsigned STEP          = STEP_DEF,
  parameter int unsigned Y_LIMIT       = SCREEN_H,
  parameter int unsigned MISSLE_W      = game_pkg::MISSLE_W,
  parameter int unsigned MISSLE_H      = game_pkg::MISSLE_H,
  parameter int unsigned PLAYER_W      = game_pkg::PLAYER_W,
  parameter int unsigned PLAYER_H      = game_pkg::PLAYER_H
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        fire_req,
  input  logic [11:0] fire_xpos,
  input  logic [11:0] fire_ypos,
  input  logic [11:0] player_xpos,
  input  logic [11:0] player_ypos,
  output logic        fire_ack,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        on_out,
  output logic        hit
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(COUNTER_LIMIT);
  localparam logic [11:0]      STEP_V  = 12'(STEP);
  localparam logic [11:0]      Y_LIM   = 12'(Y_LIMIT);
  localparam logic [11:0]      M_W     = 12'(MISSLE_W);
  localparam logic [11:0]      M_H     = 12'(MISSLE_H);
  localparam logic [11:0]      P_W     = 12'(PLAYER_W);
  localparam logic [11:0]      P_H     = 12'(PLAYER_H);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      xpos_q, xpos_d;
  logic [11:0]      ypos_q, ypos_d;
  logic             on_q, on_d;
  logic             ack_q, ack_d;
  logic             hit_q, hit_d;
  logic             overlap;

  // Collision test runs on the registered missile position.
  rect_overlap u_overlap (
    .a_x_i     (xpos_q),
    .a_y_i     (ypos_q),
    .a_w_i     (M_W),
    .a_h_i     (M_H),
    .b_x_i     (player_xpos),
    .b_y_i     (player_ypos),
    .b_w_i     (P_W),
    .b_h_i     (P_H),
    .overlap_o (overlap)
  );

  // Next-state and next-output logic for the flight FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    ack_d   = 1'b0;
    hit_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fire_req) begin
          state_d = ST_LAUNCH;
          xpos_d  = fire_xpos;
          ypos_d  = fire_ypos;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end
      end

      ST_LAUNCH: state_d = ST_FLY;

      ST_FLY: begin
        // Contact wins over reaching the bottom in the same cycle.
        if (overlap) begin
          state_d = ST_HIT;
        end else if (ypos_q >= Y_LIM) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LIM) begin
          cnt_d  = '0;
          ypos_d = step_clamp(ypos_q, STEP_V, Y_LIM);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HIT: begin
        state_d = ST_IDLE;
        hit_d   = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // Visible exactly while the missile will be flying next cycle.
    on_d = (state_d == ST_FLY);
  end

  // State and output registers; reset kills any flight without a hit.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      on_q    <= 1'b0;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      on_q    <= on_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
    end
  end

  assign fire_ack = ack_q;
  assign xpos_out = xpos_q;
  assign ypos_out = ypos_q;
  assign on_out   = on_q;
  assign hit      = hit_q;

endmodule

// File: tb/tb_enemy_missle_ctl.sv
// Directed bench for enemy_missle_ctl with a short refresh interval
// (COUNTER_LIMIT=3, so one 2-pixel step every 4 cycles in flight).
module tb_enemy_missle_ctl;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic        fire_req = 1'b0;
  logic [11:0] fire_xpos = '0, fire_ypos = '0;
  logic [11:0] player_xpos = '0, player_ypos = '0;
  logic        fire_ack, on_out, hit;
  logic [11:0] xpos_out, ypos_out;

  int total = 0;
  int bad   = 0;

  // Background observers, sampled 1ns after each rising edge.
  int          hit_cnt  = 0;
  int          both_cnt = 0;
  logic [11:0] max_y    = '0;

  always #5 pclk = ~pclk;

  enemy_missle_ctl #(
    .COUNTER_LIMIT(3),
    .STEP(2),
    .Y_LIMIT(768)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .fire_req    (fire_req),
    .fire_xpos   (fire_xpos),
    .fire_ypos   (fire_ypos),
    .player_xpos (player_xpos),
    .player_ypos (player_ypos),
    .fire_ack    (fire_ack),
    .xpos_out    (xpos_out),
    .ypos_out    (ypos_out),
    .on_out      (on_out),
    .hit         (hit)
  );

  always @(posedge pclk) begin
    #1;
    if (hit) hit_cnt++;
    if (hit && fire_ack) both_cnt++;
    if (ypos_out > max_y) max_y = ypos_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance n clocks; returns on the falling edge so outputs are stable.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      @(negedge pclk);
    end
  endtask

  // Wait (bounded) for the missile to disappear; n = clocks taken.
  task automatic wait_off(input int budget, output int n);
    n = 0;
    while (on_out === 1'b1 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (on_out !== 1'b0) begin
      bad++;
      $display("FAIL wait_off timeout: on_out=%0d after %0d cycles", on_out, n);
    end
  endtask

  task automatic launch(input logic [11:0] x, input logic [11:0] y);
    fire_xpos = x;
    fire_ypos = y;
    fire_req  = 1'b1;
    step();
    fire_req  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({fire_ack, on_out, hit, xpos_out, ypos_out} !== 27'd0) begin
      bad++;
      $display("FAIL reset_init: ack=%0d on=%0d hit=%0d x=%0d y=%0d want all 0",
               fire_ack, on_out, hit, xpos_out, ypos_out);
    end
    @(negedge pclk);
    rst = 1'b1;
    step(5);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({fire_ack, on_out, hit, xpos_out, ypos_out} !== 27'd0) begin
      bad++;
      $display("FAIL reset_mid: ack=%0d on=%0d hit=%0d x=%0d y=%0d want all 0",
               fire_ack, on_out, hit, xpos_out, ypos_out);
    end
    @(negedge pclk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (on_out !== 1'b0 || fire_ack !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet cycle %0d: on=%0d ack=%0d want 0/0", i, on_out, fire_ack);
      end
    end
  endtask

  task automatic test_launch();
    int n;
    player_xpos = 12'd1000;
    player_ypos = 12'd0;
    hit_cnt     = 0;
    launch(12'd100, 12'd50);
    total++;
    if (fire_ack !== 1'b1 || xpos_out !== 12'd100 || ypos_out !== 12'd50 || on_out !== 1'b0) begin
      bad++;
      $display("FAIL launch_ack: ack=%0d x=%0d y=%0d on=%0d want 1/100/50/0",
               fire_ack, xpos_out, ypos_out, on_out);
    end
    step();
    total++;
    if (fire_ack !== 1'b0 || on_out !== 1'b1 || ypos_out !== 12'd50) begin
      bad++;
      $display("FAIL launch_on: ack=%0d on=%0d y=%0d want 0/1/50", fire_ack, on_out, ypos_out);
    end
    step(3);
    total++;
    if (ypos_out !== 12'd50) begin
      bad++;
      $display("FAIL fly_hold3: y=%0d want 50", ypos_out);
    end
    step();
    total++;
    if (ypos_out !== 12'd52) begin
      bad++;
      $display("FAIL fly_step1: y=%0d want 52", ypos_out);
    end
    step(4);
    total++;
    if (ypos_out !== 12'd54 || xpos_out !== 12'd100) begin
      bad++;
      $display("FAIL fly_step2: x=%0d y=%0d want 100/54", xpos_out, ypos_out);
    end
    // 357 steps of 4 cycles from 54 to 768, then one cycle to retire.
    wait_off(2000, n);
    total++;
    if (n !== 1429 || ypos_out !== 12'd768 || hit_cnt !== 0) begin
      bad++;
      $display("FAIL launch_retire: cycles=%0d y=%0d hits=%0d want 1429/768/0",
               n, ypos_out, hit_cnt);
    end
  endtask

  task automatic test_miss_bottom();
    player_xpos = 12'd0;
    player_ypos = 12'd0;
    hit_cnt     = 0;
    max_y       = '0;
    launch(12'd200, 12'd764);
    step();
    step(4);
    total++;
    if (ypos_out !== 12'd766 || on_out !== 1'b1) begin
      bad++;
      $display("FAIL miss_766: y=%0d on=%0d want 766/1", ypos_out, on_out);
    end
    step(4);
    total++;
    if (ypos_out !== 12'd768 || on_out !== 1'b1) begin
      bad++;
      $display("FAIL miss_768: y=%0d on=%0d want 768/1", ypos_out, on_out);
    end
    step();
    total++;
    if (on_out !== 1'b0 || hit_cnt !== 0) begin
      bad++;
      $display("FAIL miss_retire: on=%0d hits=%0d want 0/0", on_out, hit_cnt);
    end
    // Odd start: 765 -> 767 -> 769 clamped to 768.
    launch(12'd200, 12'd765);
    step(5);
    total++;
    if (ypos_out !== 12'd767) begin
      bad++;
      $display("FAIL clamp_767: y=%0d want 767", ypos_out);
    end
    step(4);
    total++;
    if (ypos_out !== 12'd768) begin
      bad++;
      $display("FAIL clamp_768: y=%0d want 768", ypos_out);
    end
    step();
    total++;
    if (on_out !== 1'b0 || max_y !== 12'd768 || hit_cnt !== 0) begin
      bad++;
      $display("FAIL clamp_retire: on=%0d max_y=%0d hits=%0d want 0/768/0",
               on_out, max_y, hit_cnt);
    end
  endtask

  task automatic test_hit();
    int n;
    player_xpos = 12'd96;
    player_ypos = 12'd100;
    hit_cnt     = 0;
    launch(12'd100, 12'd30);
    step();
    // 28 steps reach y=86 (86+16 > 100); the next cycle enters HIT.
    wait_off(300, n);
    total++;
    if (n !== 113 || ypos_out !== 12'd86 || hit !== 1'b0) begin
      bad++;
      $display("FAIL hit_entry: cycles=%0d y=%0d hit=%0d want 113/86/0", n, ypos_out, hit);
    end
    step();
    total++;
    if (hit !== 1'b1 || on_out !== 1'b0 || fire_ack !== 1'b0) begin
      bad++;
      $display("FAIL hit_pulse: hit=%0d on=%0d ack=%0d want 1/0/0", hit, on_out, fire_ack);
    end
    step();
    total++;
    if (hit !== 1'b0 || hit_cnt !== 1) begin
      bad++;
      $display("FAIL hit_single: hit=%0d hits=%0d want 0/1", hit, hit_cnt);
    end
    // Missile right edge 108 only touches the player at x=108.
    player_xpos = 12'd108;
    hit_cnt     = 0;
    launch(12'd100, 12'd30);
    step();
    wait_off(2000, n);
    total++;
    if (n !== 1477 || ypos_out !== 12'd768 || hit_cnt !== 0) begin
      bad++;
      $display("FAIL touch_edge: cycles=%0d y=%0d hits=%0d want 1477/768/0",
               n, ypos_out, hit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    player_xpos = 12'd1000;
    player_ypos = 12'd0;
    fire_xpos   = 12'd500;
    fire_ypos   = 12'd768;
    fire_req    = 1'b1;
    step();
    total++;
    if (fire_ack !== 1'b1 || on_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ack1: ack=%0d on=%0d want 1/0", fire_ack, on_out);
    end
    step();
    total++;
    if (fire_ack !== 1'b0 || on_out !== 1'b1) begin
      bad++;
      $display("FAIL b2b_launch: ack=%0d on=%0d want 0/1", fire_ack, on_out);
    end
    step();
    total++;
    if (fire_ack !== 1'b0 || on_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_retire: ack=%0d on=%0d want 0/0", fire_ack, on_out);
    end
    step();
    total++;
    if (fire_ack !== 1'b1 || ypos_out !== 12'd768) begin
      bad++;
      $display("FAIL b2b_ack2: ack=%0d y=%0d want 1/768", fire_ack, ypos_out);
    end
    fire_req = 1'b0;
    step(3);
    total++;
    if (on_out !== 1'b0 || fire_ack !== 1'b0) begin
      bad++;
      $display("FAIL b2b_settle: on=%0d ack=%0d want 0/0", on_out, fire_ack);
    end
  endtask

  task automatic test_busy_reset();
    int n;
    player_xpos = 12'd1000;
    player_ypos = 12'd0;
    hit_cnt     = 0;
    launch(12'd300, 12'd150);
    step(3);
    fire_xpos = 12'd5;
    fire_ypos = 12'd5;
    fire_req  = 1'b1;
    step();
    fire_req  = 1'b0;
    total++;
    if (fire_ack !== 1'b0 || xpos_out !== 12'd300 || on_out !== 1'b1) begin
      bad++;
      $display("FAIL busy_ignore: ack=%0d x=%0d on=%0d want 0/300/1", fire_ack, xpos_out, on_out);
    end
    step();
    total++;
    if (fire_ack !== 1'b0 || xpos_out !== 12'd300) begin
      bad++;
      $display("FAIL busy_after: ack=%0d x=%0d want 0/300", fire_ack, xpos_out);
    end
    n = 0;
    while (ypos_out !== 12'd200 && n < 300) begin
      step();
      n++;
    end
    total++;
    if (ypos_out !== 12'd200 || on_out !== 1'b1) begin
      bad++;
      $display("FAIL busy_reach200: y=%0d on=%0d want 200/1", ypos_out, on_out);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (on_out !== 1'b0 || hit !== 1'b0 || ypos_out !== 12'd0 || xpos_out !== 12'd0) begin
      bad++;
      $display("FAIL async_kill: on=%0d hit=%0d x=%0d y=%0d want 0/0/0/0",
               on_out, hit, xpos_out, ypos_out);
    end
    @(negedge pclk);
    step();
    rst = 1'b1;
    step();
    total++;
    if (hit_cnt !== 0 || on_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_nohit: hits=%0d on=%0d want 0/0", hit_cnt, on_out);
    end
    launch(12'd400, 12'd60);
    total++;
    if (fire_ack !== 1'b1 || xpos_out !== 12'd400 || ypos_out !== 12'd60) begin
      bad++;
      $display("FAIL relaunch_ack: ack=%0d x=%0d y=%0d want 1/400/60",
               fire_ack, xpos_out, ypos_out);
    end
    step();
    total++;
    if (on_out !== 1'b1) begin
      bad++;
      $display("FAIL relaunch_on: on=%0d want 1", on_out);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_miss_bottom();
    test_hit();
    test_back_to_back();
    test_busy_reset();
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL ack_hit_exclusive: overlapping cycles=%0d want 0", both_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
